// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared multiply/divide op codes, cycle defaults and result type
package mdu_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MADD  = 3'd6;
  localparam logic [2:0] MD_MADDU = 3'd7;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  typedef logic [63:0] md_res_t;

endpackage

// File: rtl/e_mdu_if.sv
// rtl/e_mdu_if.sv - ID/EX operand request and HI/LO/busy result bundle
interface e_mdu_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, a, b, input busy, hi, lo);
  modport slave  (input start, md_op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational product/quotient/accumulate result (optional MDU_MADD_EN)
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output md_res_t     res
);

  logic        sgn;
  logic [31:0] a_mag, b_mag, q_u, r_u, q, r;
  logic [63:0] prod_s, prod_u;

  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
    // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly.
    sgn    = (md_op == MD_DIV);
    a_mag  = (sgn && a[31]) ? (~a + 32'd1) : a;
    b_mag  = (sgn && b[31]) ? (~b + 32'd1) : b;
    q_u    = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    r_u    = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    q      = (sgn && (a[31] ^ b[31])) ? (~q_u + 32'd1) : q_u;
    r      = (sgn && a[31]) ? (~r_u + 32'd1) : r_u;

    res = {hi, lo};
    case (md_op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV, MD_DIVU: begin
        if (b != 32'd0) res = {r, q};
      end
`ifdef MDU_MADD_EN
      MD_MADD:  res = {hi, lo} + prod_s;
      MD_MADDU: res = {hi, lo} + prod_u;
`endif
      default:  res = {hi, lo};
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - execute-stage multiply/divide unit with HI/LO and busy counter
// Optional multiply-accumulate (md_op 6/7) enabled by MDU_MADD_EN.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
)(
  input logic     clk,
  input logic     reset,
  e_mdu_if.slave  bus
);

  logic [3:0]  cnt;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  md_res_t     shadow, res;

  mdu_arith u_arith (
    .md_op (bus.md_op),
    .a     (bus.a),
    .b     (bus.b),
    .hi    (hi_q),
    .lo    (lo_q),
    .res   (res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= 4'd0;
      busy_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      shadow <= '0;
    end else if (busy_q) begin
      // Requests arriving while busy are dropped; the hazard unit should prevent them.
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        busy_q <= 1'b0;
        hi_q   <= shadow[63:32];
        lo_q   <= shadow[31:0];
      end
    end else if (bus.start) begin
      case (bus.md_op)
        MD_MULT, MD_MULTU: begin
          shadow <= res;
          cnt    <= 4'(MULT_CYC);
          busy_q <= 1'b1;
        end
        MD_DIV, MD_DIVU: begin
          shadow <= res;
          cnt    <= 4'(DIV_CYC);
          busy_q <= 1'b1;
        end
`ifdef MDU_MADD_EN
        MD_MADD, MD_MADDU: begin
          shadow <= res;
          cnt    <= 4'(MULT_CYC);
          busy_q <= 1'b1;
        end
`endif
        MD_MTHI: hi_q <= bus.a;
        MD_MTLO: lo_q <= bus.a;
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - table-driven scoreboard bench for e_mdu
module tb_e_mdu;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vec_cnt = 0;
  int   miss_cnt = 0;
  int   viol_cnt = 0;
  vec_t vt[$];
  exp_t exp_q[$];

  e_mdu_if bus ();

  e_mdu #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Protocol monitor: a request presented while the unit is busy.
  always @(posedge clk) begin
    if (reset && bus.start && bus.busy) viol_cnt <= viol_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vec_cnt++;
    if (act !== req) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic preload(input logic [31:0] h, input logic [31:0] l);
    do_op(MD_MTHI, h, 32'd0);
    check("mthi_hi", bus.hi, h);
    check("mthi_busy", 32'(bus.busy), 32'd0);
    do_op(MD_MTLO, l, 32'd0);
    check("mtlo_lo", bus.lo, l);
    check("mtlo_hi_kept", bus.hi, h);
  endtask

  initial begin
    int   n;
    exp_t e;

    vt.push_back('{MD_MULT,  32'd3,        32'hFFFFFFFE, 32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFA, MC});
    vt.push_back('{MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'h0,  32'h0,  32'h00000001, 32'hFFFFFFFE, MC});
    vt.push_back('{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFD, DC});
    vt.push_back('{MD_DIVU,  32'd7,        32'd0,        32'h11, 32'h22, 32'h00000011, 32'h00000022, DC});
    vt.push_back('{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h5,  32'h6,  32'h00000000, 32'h80000000, DC});
    vt.push_back('{MD_DIVU,  32'd100,      32'd7,        32'h0,  32'h0,  32'h00000002, 32'h0000000E, DC});
    vt.push_back('{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h0,  32'h0,  32'h00000001, 32'hFFFFFFFD, DC});
    vt.push_back('{MD_MULT,  32'h80000000, 32'h80000000, 32'h0,  32'h0,  32'h40000000, 32'h00000000, MC});
    vt.push_back('{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,  32'h0,  32'hFFFFFFFE, 32'h00000001, MC});
    vt.push_back('{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h9,  32'h9,  32'h00000000, 32'h00000001, MC});
    vt.push_back('{MD_MULT,  32'd0,        32'h12345678, 32'h77, 32'h88, 32'h00000000, 32'h00000000, MC});
`ifdef MDU_MADD_EN
    vt.push_back('{MD_MADDU, 32'd1,        32'd1,        32'h0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, MC});
    vt.push_back('{MD_MADD,  32'hFFFFFFFF, 32'd2,        32'h0,  32'h5,  32'h00000000, 32'h00000003, MC});
`else
    vt.push_back('{MD_MADD,  32'd1,        32'd1,        32'h33, 32'h44, 32'h00000033, 32'h00000044, 0});
    vt.push_back('{MD_MADDU, 32'd5,        32'd5,        32'h55, 32'h66, 32'h00000055, 32'h00000066, 0});
`endif

    bus.start = 1'b0;
    bus.md_op = 3'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    reset = 1'b1;

    foreach (vt[i]) begin
      preload(vt[i].pre_hi, vt[i].pre_lo);
      exp_q.push_back('{vt[i].exp_hi, vt[i].exp_lo});
      do_op(vt[i].op, vt[i].a, vt[i].b);
      wait_done(n);
      check($sformatf("vec%0d_busy_cycles", i), 32'(n), 32'(vt[i].cyc));
      e = exp_q.pop_front();
      check($sformatf("vec%0d_hi", i), bus.hi, e.hi);
      check($sformatf("vec%0d_lo", i), bus.lo, e.lo);
    end

    // Request on busy cycle 2 must be ignored.
    preload(32'h0, 32'h0);
    exp_q.push_back('{32'h0, 32'h00012340});
    do_op(MD_MULT, 32'h1234, 32'h10);
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = MD_MTLO;
    bus.a     = 32'hDEAD;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    check("ovl_busy_cycles", 32'(n + 2), 32'(MC));
    e = exp_q.pop_front();
    check("ovl_hi", bus.hi, e.hi);
    check("ovl_lo", bus.lo, e.lo);
    check("ovl_flagged", 32'(viol_cnt), 32'd1);

    // Asynchronous reset between edges in the middle of a divide.
    preload(32'h55, 32'h66);
    do_op(MD_DIVU, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_hi", bus.hi, 32'd0);
    check("arst_lo", bus.lo, 32'd0);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("arst_no_commit_busy", 32'(bus.busy), 32'd0);
    check("arst_no_commit_hi", bus.hi, 32'd0);
    check("arst_no_commit_lo", bus.lo, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
